fifo_ctrl: RTL and testbench

- Pointer and flag controller that sits directly upstream of the 8x10 dual-address RAM (Memoria_RAM) and turns it into a FIFO.
- Converts push/pop requests into the RAM's we_a/re_a/addr_wa/addr_ra.
- Tracks occupancy, raises full/empty/almost flags and overflow/underflow errors.
- Exposes a 4-bit FSM state for the system-level probe.

---
 rtl/fifo_pkg.sv | 16 +
 rtl/fifo_ptr.sv | 34 +++
 rtl/fifo_ctrl.sv | 137 +++++++++++++
 tb/tb_fifo_ctrl.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared constants for the FIFO controller and its pointer registers.
package fifo_pkg;

  localparam int unsigned DEF_DATA_W = 10;
  localparam int unsigned DEF_ADDR_W = 3;
  localparam int unsigned DEF_DEPTH  = 8;
  localparam int unsigned PTR_W      = DEF_ADDR_W + 1;
  localparam int unsigned ST_W       = 4;

  localparam logic [ST_W-1:0] ST_RESET  = 4'd0;
  localparam logic [ST_W-1:0] ST_INIT   = 4'd1;
  localparam logic [ST_W-1:0] ST_IDLE   = 4'd2;
  localparam logic [ST_W-1:0] ST_ACTIVE = 4'd3;
  localparam logic [ST_W-1:0] ST_ERROR  = 4'd4;

endpackage

// File: rtl/fifo_ptr.sv
// Wrap-bit pointer: counts modulo 2*DEPTH; the MSB distinguishes full from empty.
module fifo_ptr
  import fifo_pkg::*;
#(
  parameter int unsigned W = PTR_W
) (
  input  logic         clk,
  input  logic         reset_L,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] ptr,
  output logic [W-1:0] ptr_nxt_c
);

  // Next pointer value; clear has priority over increment.
  always_comb begin
    ptr_nxt_c = ptr;
    if (clr) begin
      ptr_nxt_c = '0;
    end else if (inc) begin
      ptr_nxt_c = ptr + W'(1);
    end
  end

  // Pointer register.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      ptr <= '0;
    end else begin
      ptr <= ptr_nxt_c;
    end
  end

endmodule

// File: rtl/fifo_ctrl.sv
// FIFO pointer/flag controller driving a dual-address RAM; DEPTH must equal 2**ADDR_W.
module fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DEPTH  = DEF_DEPTH
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic              init,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W:0]   umbral_af,
  input  logic [ADDR_W:0]   umbral_ae,
  output logic              we_a,
  output logic              re_a,
  output logic [ADDR_W-1:0] addr_wa,
  output logic [ADDR_W-1:0] addr_ra,
  output logic [ADDR_W:0]   fill,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic              err_overflow,
  output logic              err_underflow,
  output logic [ST_W-1:0]   state
);

  localparam int unsigned PW = ADDR_W + 1;

  logic [ST_W-1:0] state_nxt;
  logic [PW-1:0]   wr_ptr, rd_ptr, wr_nxt, rd_nxt, fill_nxt;
  logic [PW-1:0]   af_thr, ae_thr, af_thr_nxt, ae_thr_nxt;
  logic            accept_c, clr_c, load_c;
  logic            push_ok, pop_ok, ovf_c, unf_c;

  // Requests are honoured only in IDLE/ACTIVE and never alongside an init request.
  assign accept_c = ((state == ST_IDLE) || (state == ST_ACTIVE)) && !init;
  assign push_ok  = accept_c && push && !full;
  assign pop_ok   = accept_c && pop && !empty;
  assign ovf_c    = accept_c && push && full;
  assign unf_c    = accept_c && pop && empty;

  // Entering INIT (from reset, an init request, or an illegal code) clears pointers and errors.
  assign clr_c  = (state == ST_RESET) || init || (state > ST_ERROR);
  assign load_c = clr_c || (state == ST_INIT);

  assign we_a    = push_ok;
  assign re_a    = pop_ok;
  assign addr_wa = wr_ptr[ADDR_W-1:0];
  assign addr_ra = rd_ptr[ADDR_W-1:0];

  fifo_ptr #(.W(PW)) u_wr_ptr (
    .clk       (clk),
    .reset_L   (reset_L),
    .clr       (clr_c),
    .inc       (push_ok),
    .ptr       (wr_ptr),
    .ptr_nxt_c (wr_nxt)
  );

  fifo_ptr #(.W(PW)) u_rd_ptr (
    .clk       (clk),
    .reset_L   (reset_L),
    .clr       (clr_c),
    .inc       (pop_ok),
    .ptr       (rd_ptr),
    .ptr_nxt_c (rd_nxt)
  );

  // Occupancy and thresholds as they will be after the coming edge.
  always_comb begin
    fill_nxt   = wr_nxt - rd_nxt;
    af_thr_nxt = af_thr;
    ae_thr_nxt = ae_thr;
    if (load_c) begin
      af_thr_nxt = umbral_af;
      ae_thr_nxt = umbral_ae;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_RESET: state_nxt = ST_INIT;
      ST_INIT:  if (!init) state_nxt = ST_IDLE;
      ST_IDLE: begin
        if (init)         state_nxt = ST_INIT;
        else if (unf_c)   state_nxt = ST_ERROR;
        else if (push_ok) state_nxt = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (init)                     state_nxt = ST_INIT;
        else if (ovf_c || unf_c)      state_nxt = ST_ERROR;
        else if (fill_nxt == PW'(0))  state_nxt = ST_IDLE;
      end
      ST_ERROR: if (init) state_nxt = ST_INIT;
      default:  state_nxt = ST_INIT;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state <= ST_RESET;
    end else begin
      state <= state_nxt;
    end
  end

  // Registered thresholds, occupancy, status and sticky error flags.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      af_thr        <= '0;
      ae_thr        <= '0;
      fill          <= '0;
      full          <= 1'b0;
      empty         <= 1'b1;
      almost_full   <= 1'b0;
      almost_empty  <= 1'b0;
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      af_thr        <= af_thr_nxt;
      ae_thr        <= ae_thr_nxt;
      fill          <= fill_nxt;
      full          <= (fill_nxt == PW'(DEPTH));
      empty         <= (fill_nxt == PW'(0));
      almost_full   <= (fill_nxt >= af_thr_nxt);
      almost_empty  <= (fill_nxt <= ae_thr_nxt);
      err_overflow  <= clr_c ? 1'b0 : (err_overflow | ovf_c);
      err_underflow <= clr_c ? 1'b0 : (err_underflow | unf_c);
    end
  end

endmodule

// File: tb/tb_fifo_ctrl.sv
// Bench for fifo_ctrl: occupancy-count model checked every cycle plus directed literal checks.
module tb_fifo_ctrl;

  localparam int unsigned AW = 3;

  logic          clk = 1'b0;
  logic          reset_L, init, push, pop;
  logic [AW:0]   umbral_af, umbral_ae;
  logic          we_a, re_a;
  logic [AW-1:0] addr_wa, addr_ra;
  logic [AW:0]   fill;
  logic          full, empty, almost_full, almost_empty;
  logic          err_overflow, err_underflow;
  logic [3:0]    state;

  int n_cmp = 0;
  int n_bad = 0;

  // model: write/read counts mod 16, mode number, thresholds, sticky errors
  int m_st, m_wr, m_rd, m_af, m_ae;
  bit m_ovf, m_unf;

  fifo_ctrl dut (
    .clk           (clk),
    .reset_L       (reset_L),
    .init          (init),
    .push          (push),
    .pop           (pop),
    .umbral_af     (umbral_af),
    .umbral_ae     (umbral_ae),
    .we_a          (we_a),
    .re_a          (re_a),
    .addr_wa       (addr_wa),
    .addr_ra       (addr_ra),
    .fill          (fill),
    .full          (full),
    .empty         (empty),
    .almost_full   (almost_full),
    .almost_empty  (almost_empty),
    .err_overflow  (err_overflow),
    .err_underflow (err_underflow),
    .state         (state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int m_fill();
    return (m_wr - m_rd) & 15;
  endfunction

  function automatic bit m_accept();
    return reset_L && (m_st == 2 || m_st == 3) && !init;
  endfunction

  task automatic model_reset();
    m_st = 0; m_wr = 0; m_rd = 0; m_af = 0; m_ae = 0; m_ovf = 0; m_unf = 0;
  endtask

  // Expected outputs from the model for the current cycle and inputs.
  task automatic compare();
    int f;
    f = m_fill();
    chk("state", state, m_st);
    chk("fill", fill, f);
    chk("full", full, int'(f == 8));
    chk("empty", empty, int'(f == 0));
    chk("almost_full", almost_full, int'(m_st != 0 && f >= m_af));
    chk("almost_empty", almost_empty, int'(m_st != 0 && f <= m_ae));
    chk("err_overflow", err_overflow, int'(m_ovf));
    chk("err_underflow", err_underflow, int'(m_unf));
    chk("we_a", we_a, int'(m_accept() && push && f != 8));
    chk("re_a", re_a, int'(m_accept() && pop && f != 0));
    chk("addr_wa", addr_wa, m_wr % 8);
    chk("addr_ra", addr_ra, m_rd % 8);
  endtask

  // Advance the model across one rising edge.
  task automatic model_edge();
    int f;
    bit acc, pok, rok, ov, un;
    f   = m_fill();
    acc = m_accept();
    pok = acc && push && f != 8;
    rok = acc && pop && f != 0;
    ov  = acc && push && f == 8;
    un  = acc && pop && f == 0;
    if (!reset_L) begin
      model_reset();
    end else if (m_st == 0) begin
      m_af = int'(umbral_af); m_ae = int'(umbral_ae); m_st = 1;
    end else if (init) begin
      m_wr = 0; m_rd = 0; m_ovf = 0; m_unf = 0;
      m_af = int'(umbral_af); m_ae = int'(umbral_ae); m_st = 1;
    end else if (m_st == 1) begin
      m_af = int'(umbral_af); m_ae = int'(umbral_ae); m_st = 2;
    end else if (m_st == 2 || m_st == 3) begin
      m_wr = (m_wr + int'(pok)) % 16;
      m_rd = (m_rd + int'(rok)) % 16;
      m_ovf = m_ovf | ov;
      m_unf = m_unf | un;
      if (ov || un)         m_st = 4;
      else if (m_fill() == 0) m_st = 2;
      else                  m_st = 3;
    end
  endtask

  task automatic step();
    @(negedge clk);
    compare();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  int exp_wa[6] = '{5, 6, 7, 0, 1, 2};
  logic [AW-1:0] wa0, ra0;

  initial begin
    reset_L = 1'b0; init = 1'b0; push = 1'b0; pop = 1'b0;
    umbral_af = 4'd6; umbral_ae = 4'd1;
    model_reset();
    step(); step();
    chk("rst_state", state, 0);
    chk("rst_fill", fill, 0);
    chk("rst_empty", empty, 1);
    chk("rst_almost_full", almost_full, 0);
    chk("rst_almost_empty", almost_empty, 0);

    reset_L = 1'b1; init = 1'b1;
    step();
    chk("init_state", state, 1);
    step();
    init = 1'b0;
    step();
    chk("idle_state", state, 2);
    chk("idle_empty", empty, 1);
    chk("idle_almost_empty", almost_empty, 1);

    // fill to 8
    push = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("push_addr_wa", addr_wa, i);
      chk("push_we_a", we_a, 1);
      step();
      if (i == 4) chk("almost_full_at5", almost_full, 0);
      if (i == 5) chk("almost_full_at6", almost_full, 1);
    end
    chk("full_at8", full, 1);
    chk("active_state", state, 3);

    // drain in order
    push = 1'b0; pop = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("pop_addr_ra", addr_ra, i);
      chk("pop_re_a", re_a, 1);
      step();
    end
    pop = 1'b0;
    chk("drained_empty", empty, 1);
    chk("drained_state", state, 2);

    // wrap-around
    push = 1'b1;
    repeat (5) step();
    push = 1'b0; pop = 1'b1;
    repeat (5) step();
    pop = 1'b0; push = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("wrap_addr_wa", addr_wa, exp_wa[i]);
      step();
    end
    push = 1'b0;
    chk("wrap_fill", fill, 6);
    chk("wrap_full", full, 0);

    // simultaneous push/pop at fill 3
    pop = 1'b1;
    repeat (3) step();
    wa0 = addr_wa; ra0 = addr_ra;
    push = 1'b1;
    repeat (4) step();
    chk("simul_fill", fill, 3);
    chk("simul_wa_adv", 3'(addr_wa - wa0), 4);
    chk("simul_ra_adv", 3'(addr_ra - ra0), 4);

    // simultaneous at full -> overflow
    pop = 1'b0;
    repeat (5) step();
    chk("refill_full", full, 1);
    pop = 1'b1;
    #1;
    chk("ovf_re_a", re_a, 1);
    chk("ovf_we_a", we_a, 0);
    step();
    chk("ovf_flag", err_overflow, 1);
    chk("ovf_state", state, 4);
    chk("ovf_fill", fill, 7);
    pop = 1'b0;
    #1;
    chk("error_we_a", we_a, 0);
    step();
    chk("error_fill_hold", fill, 7);

    push = 1'b0; init = 1'b1;
    step();
    chk("reinit_state", state, 1);
    chk("reinit_ovf_clr", err_overflow, 0);
    chk("reinit_fill", fill, 0);
    init = 1'b0;
    step();

    // underflow in IDLE
    pop = 1'b1;
    #1;
    chk("unf_re_a", re_a, 0);
    step();
    chk("unf_flag", err_underflow, 1);
    chk("unf_state", state, 4);
    pop = 1'b0; push = 1'b1;
    #1;
    chk("unf_error_we_a", we_a, 0);
    step();
    chk("unf_error_fill", fill, 0);
    push = 1'b0; init = 1'b1;
    step();
    chk("reinit2_state", state, 1);
    chk("reinit2_unf_clr", err_underflow, 0);
    init = 1'b0;
    step();

    // asynchronous reset mid-burst
    push = 1'b1;
    repeat (5) step();
    chk("burst_fill", fill, 5);
    reset_L = 1'b0;
    #1;
    model_reset();
    chk("async_fill", fill, 0);
    chk("async_empty", empty, 1);
    chk("async_state", state, 0);
    chk("async_we_a", we_a, 0);
    chk("async_re_a", re_a, 0);
    push = 1'b0;
    step();
    reset_L = 1'b1; init = 1'b1;
    step();
    init = 1'b0;
    step(); step();
    chk("recover_state", state, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
